bloco_controle: RTL and testbench
=================================

// Module: bloco_controle
// PURPOSE
//   Sequencer for bloco_operacional. On start, drives LX/LS/LH/H/M0/M1/M2 so
//   the datapath computes Resultado = A*X [+B] [-C] by repeated addition.
//   Keeps its own down-counter for X, collects Overflow into a sticky flag,
//   and signals completion with a one-cycle done pulse.
//   Datapath semantics driven here: ULA = M2_OUT + M1_OUT (H=0) or
//   M2_OUT - M1_OUT (H=1). Register loads happen on clk when L*=1.
// PARAMETERS
//   CNT_W   8   width of X and of the iteration counter
// PORTS
//   clk       in   1      clock, rising edge
//   rst_n     in   1      synchronous reset, active-low
//   start     in   1      begin operation; sampled only in IDLE
//   op        in   2      op[0]=add B after product, op[1]=subtract C at end
//   X         in   CNT_W  multiplier; same bus as datapath X, sampled with start
//   Overflow  in   1      datapath ULA overflow
//   LX,LS,LH  out  1      datapath register load enables
//   H         out  1      ULA mode: 0=add, 1=subtract
//   M0,M1,M2  out  2      datapath mux selects
//   busy      out  1      1 in every state except IDLE
//   done      out  1      one-cycle pulse; Resultado valid from this cycle
//   erro      out  1      sticky overflow of the last operation
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE, cnt=0, op_q=0, erro=0.
//     All outputs are 0 in the cycle after. Reset mid-operation aborts at once.
//   Defaults in every state: LX=LS=LH=H=0, M0=M1=M2=0.
//   IDLE: busy=0. Decode uses the live op input in this state only.
//     start=1 -> LX=1, LS=1, LH=1, M0=00, M1=00, M2=01, H=0, giving RS=RH=0.
//       op_q<=op, cnt<=X, erro<=0.
//       next = LOOP if X!=0, else POST(op).
//   LOOP: M2=10 (RS), M0=01 (A), M1=00, H=0, LS=1 gives RS<=RS+A.
//     cnt<=cnt-1. next = LOOP if cnt!=1, else POST(op_q).
//   ADDB: M2=10, M0=10 (B), M1=00, H=0, LS=1 gives RS<=RS+B.
//     next = SUBC if op_q[1], else DONE.
//   SUBC: M2=10, M0=11 (C), M1=00, H=1, LS=1 gives RS<=RS-C. next = DONE.
//   DONE: done=1, busy=1, no loads. next = IDLE. start here is ignored.
//   POST(o): ADDB if o[0], else SUBC if o[1], else DONE.
//   erro <= erro | Overflow in every LOOP/ADDB/SUBC cycle (LS=1, not clear).
//     The clear cycle's Overflow is ignored. erro holds until the next start.
//   Latency: start sampled at edge t. done is high in cycle
//     t+1+X+op[0]+op[1]. Back-to-back: start is accepted in the cycle after done.
//   Arithmetic: 16-bit two's complement wrap, done by the datapath.
//     The product wraps mod 2^16. X is unsigned.
//   X=0: no LOOP cycles. Result = 0 [+B] [-C].
//   Max X=2^CNT_W-1: cnt must not wrap before exit (exit on cnt==1).
//   start while busy: ignored; op_q and cnt unchanged.
// TESTING
//   A=3, X=5, op=00, start 1 cycle -> done 6 cycles later, Resultado=15, erro=0.
//   A=7, B=100, C=20, X=4, op=11 -> done after 7 cycles, Resultado=108.
//   X=0, B=9, C=4, op=11 -> done after 3 cycles, Resultado=5. No LOOP state.
//   A=16'h4000, X=2, op=00 -> Overflow during LOOP, erro=1 at done.
//     A fresh start with A=1, X=1 then clears erro to 0.
//   Reset low for 1 cycle mid-LOOP (A=1, X=200) -> next cycle busy=0, all ctrl=0.
//     A new start then completes normally.
//   start pulsed during LOOP and DONE -> ignored.
//     Only one done per accepted start, and op_q is unchanged.

Source files
------------

// File: rtl/bloco_controle.sv
// Sequencer for bloco_operacional: computes Resultado = A*X [+B] [-C] by repeated addition,
// tracking iterations in a local down-counter and folding datapath overflow into a sticky flag.
module bloco_controle #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] X,
  input  logic             Overflow,
  output logic             LX,
  output logic             LS,
  output logic             LH,
  output logic             H,
  output logic [1:0]       M0,
  output logic [1:0]       M1,
  output logic [1:0]       M2,
  output logic             busy,
  output logic             done,
  output logic             erro
);

  typedef enum logic [2:0] {
    StIdle,
    StLoop,
    StAddB,
    StSubC,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             erro_q, erro_d;

  // State that follows the product phase (or the clear, when X == 0).
  function automatic state_e post_state(input logic [1:0] o);
    if (o[0]) begin
      return StAddB;
    end else if (o[1]) begin
      return StSubC;
    end
    return StDone;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      erro_q  <= erro_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    erro_d  = erro_q;
    LX      = 1'b0;
    LS      = 1'b0;
    LH      = 1'b0;
    H       = 1'b0;
    M0      = 2'b00;
    M1      = 2'b00;
    M2      = 2'b00;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // 0 + 0 through the ULA clears RS and RH while X is latched.
          LX      = 1'b1;
          LS      = 1'b1;
          LH      = 1'b1;
          M2      = 2'b01;
          op_d    = op;
          cnt_d   = X;
          erro_d  = 1'b0;
          state_d = (X != '0) ? StLoop : post_state(op);
        end
      end
      StLoop: begin
        M2     = 2'b10;
        M0     = 2'b01;
        LS     = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        erro_d = erro_q | Overflow;
        // Exit on 1 so the counter never wraps, even for the largest X.
        state_d = (cnt_q != CNT_W'(1)) ? StLoop : post_state(op_q);
      end
      StAddB: begin
        M2      = 2'b10;
        M0      = 2'b10;
        LS      = 1'b1;
        erro_d  = erro_q | Overflow;
        state_d = op_q[1] ? StSubC : StDone;
      end
      StSubC: begin
        M2      = 2'b10;
        M0      = 2'b11;
        H       = 1'b1;
        LS      = 1'b1;
        erro_d  = erro_q | Overflow;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign erro = erro_q;

endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: a behavioural datapath closes the loop, a scoreboard holds the
// expected result, overflow flag and latency of each accepted start.
module tb_bloco_controle;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  X = 8'd0;
  logic        Overflow;
  logic        LX, LS, LH, H, busy, done, erro;
  logic [1:0]  M0, M1, M2;

  logic [15:0] A = '0, B = '0, C = '0;
  logic [15:0] rs_q = '0, rh_q = '0, rx_q = '0;
  logic [15:0] m0_out, m1_out, m2_out, ula;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  bloco_controle #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .X(X), .Overflow(Overflow),
    .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0), .M1(M1), .M2(M2),
    .busy(busy), .done(done), .erro(erro)
  );

  always #5 clk = ~clk;

  // Datapath model: M0 picks 0/A/B/C, M1=00 passes M0, M2 picks 0 or RS.
  always_comb begin
    case (M0)
      2'b01:   m0_out = A;
      2'b10:   m0_out = B;
      2'b11:   m0_out = C;
      default: m0_out = 16'd0;
    endcase
    m1_out = (M1 == 2'b00) ? m0_out : rh_q;
    m2_out = (M2 == 2'b10) ? rs_q : 16'd0;
    ula    = H ? (m2_out - m1_out) : (m2_out + m1_out);
    if (H) Overflow = (m2_out[15] != m1_out[15]) && (ula[15] != m2_out[15]);
    else   Overflow = (m2_out[15] == m1_out[15]) && (ula[15] != m2_out[15]);
  end

  always @(posedge clk) begin
    if (LS) rs_q <= ula;
    if (LH) rh_q <= ula;
    if (LX) rx_q <= {8'd0, X};
  end

  function automatic exp_t model(input logic [15:0] a, b, c, input logic [7:0] x,
                                 input logic [1:0] o);
    exp_t e;
    logic [15:0] rs, s;
    rs = 16'd0;
    e.err = 1'b0;
    for (int i = 0; i < int'(x); i++) begin
      s = rs + a;
      if (rs[15] == a[15] && s[15] != rs[15]) e.err = 1'b1;
      rs = s;
    end
    if (o[0]) begin
      s = rs + b;
      if (rs[15] == b[15] && s[15] != rs[15]) e.err = 1'b1;
      rs = s;
    end
    if (o[1]) begin
      s = rs - c;
      if (rs[15] != c[15] && s[15] != rs[15]) e.err = 1'b1;
      rs = s;
    end
    e.res = rs;
    e.lat = 1 + int'(x) + int'(o[0]) + int'(o[1]);
    return e;
  endfunction

  task automatic run_op(input logic [15:0] a, b, c, input logic [7:0] x, input logic [1:0] o,
                        input string name);
    exp_t e;
    int   lat;
    bit   seen;
    exp_q.push_back(model(a, b, c, x, o));
    @(posedge clk);
    #1;
    A = a; B = b; C = c; X = x; op = o; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen, required within %0d cycles", name, e.lat);
      return;
    end
    n_checks++;
    if (rs_q !== e.res) begin
      n_fail++;
      $display("FAIL %s result: got %0d required %0d", name, rs_q, e.res);
    end
    n_checks++;
    if (erro !== e.err) begin
      n_fail++;
      $display("FAIL %s erro: got %b required %b", name, erro, e.err);
    end
    n_checks++;
    if (lat !== e.lat || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency/busy: got %0d/%b required %0d/1", name, lat, busy, e.lat);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({LX, LS, LH, H, M0, M1, M2, busy, done, erro} !== 13'd0) begin
      n_fail++;
      $display("FAIL %s outputs: got %b required all zero", name,
               {LX, LS, LH, H, M0, M1, M2, busy, done, erro});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(16'd3, 16'd0, 16'd0, 8'd5, 2'b00, "mul_3x5");
    run_op(16'd7, 16'd100, 16'd20, 8'd4, 2'b11, "mul_add_sub");
    run_op(16'd0, 16'd9, 16'd4, 8'd0, 2'b11, "x_zero_add_sub");
    run_op(16'd5, 16'd9, 16'd0, 8'd0, 2'b00, "x_zero_plain");
    run_op(16'd11, 16'd0, 16'd50, 8'd3, 2'b10, "mul_sub_only");
  endtask

  task automatic test_overflow();
    run_op(16'h4000, 16'd0, 16'd0, 8'd2, 2'b00, "overflow_set");
    @(negedge clk);
    n_checks++;
    if (erro !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_hold: got %b required 1", erro);
    end
    run_op(16'd1, 16'd0, 16'd0, 8'd1, 2'b00, "overflow_clear");
    run_op(16'h7fff, 16'd1, 16'd0, 8'd1, 2'b01, "overflow_addb");
  endtask

  task automatic test_max_x();
    run_op(16'd1, 16'd0, 16'd0, 8'd255, 2'b00, "max_x");
  endtask

  task automatic test_back_to_back();
    run_op(16'd2, 16'd1, 16'd0, 8'd3, 2'b01, "b2b_first");
    run_op(16'd9, 16'd0, 16'd3, 8'd2, 2'b10, "b2b_second");
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    A = 16'd1; X = 8'd200; op = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    run_op(16'd4, 16'd0, 16'd0, 8'd6, 2'b00, "after_reset_mid");
  endtask

  task automatic test_start_ignored();
    int extra;
    exp_t e;
    bit seen;
    exp_q.push_back(model(16'd6, 16'd10, 16'd0, 8'd6, 2'b01));
    @(posedge clk);
    #1;
    A = 16'd6; B = 16'd10; C = 16'd1; X = 8'd6; op = 2'b01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1; op = 2'b10; X = 8'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || rs_q !== e.res) begin
      n_fail++;
      $display("FAIL start_ignored result: got %0d (done %b) required %0d", rs_q, seen, e.res);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored extra_done: got %0d done/busy %b required 0/0", extra, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom_range(0, 12)),
             2'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_max_x();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
